serial_ip_unit: RTL and testbench

SERIAL_IP_UNIT -- requirements
Module: serial_ip_unit

---
 rtl/serial_ip_unit.sv | 99 +++++++++
 tb/tb_serial_ip_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_ip_unit.sv
// Bit-serial inner product: MSB-first neuron bits against latched weights.
// Define SIP_SIGNED_NEURON_EN for two's complement neurons (MSB subtracts).
module serial_ip_unit #(
  parameter int WL        = 16,
  parameter int LANES     = 16,
  parameter int PREC_BITS = 5,
  parameter int ACC_W     = 36
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [PREC_BITS-1:0]   i_prec,
  input  logic [LANES*WL-1:0]    i_weights,
  input  logic [LANES-1:0]       i_bits,
  input  logic                   i_bit_valid,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [ACC_W-1:0]       o_sum
);

  localparam int PW = WL + $clog2(LANES);
  localparam int CW = PREC_BITS + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  state_t                   state_nx;
  logic [LANES*WL-1:0]      w_q;
  logic [CW-1:0]            p_q;
  logic [CW-1:0]            cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [PW-1:0]     partial;
  logic signed [ACC_W-1:0]  part_ext;
  logic signed [ACC_W-1:0]  acc_nx;
  logic signed [WL-1:0]     wk;
  logic                     take;
  logic                     last;
  logic                     first;

  always_comb begin
    partial = '0;
    wk      = '0;
    for (int k = 0; k < LANES; k++) begin
      wk = w_q[k*WL +: WL];
      if (i_bits[k]) partial = partial + PW'(wk);
    end
  end

  assign part_ext = ACC_W'(partial);
  assign take     = (state == RUN) && i_bit_valid;
  assign last     = take && ((cnt_q + CW'(1)) == p_q);
  assign first    = (cnt_q == '0);

`ifdef SIP_SIGNED_NEURON_EN
  assign acc_nx = first ? (acc_q <<< 1) - part_ext
                        : (acc_q <<< 1) + part_ext;
`else
  assign acc_nx = (acc_q <<< 1) + part_ext;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (i_start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_start) begin
        w_q   <= i_weights;
        p_q   <= (i_prec == '0) ? CW'(16) : CW'(i_prec);
        cnt_q <= '0;
        acc_q <= '0;
      end else if (take) begin
        acc_q <= acc_nx;
        cnt_q <= cnt_q + CW'(1);
        if (last) sum_q <= acc_nx;
      end
    end
  end

  assign o_busy  = (state == RUN);
  assign o_valid = (state == DONE);
  assign o_sum   = sum_q;

endmodule

// File: tb/tb_serial_ip_unit.sv
// Directed bench for serial_ip_unit; expectations follow the
// SIP_SIGNED_NEURON_EN setting of the build.
module tb_serial_ip_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [4:0]   i_prec;
  logic [255:0] i_weights;
  logic [15:0]  i_bits;
  logic         i_bit_valid;
  logic         o_busy;
  logic         o_valid;
  logic [35:0]  o_sum;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] W_ONE   = {16{16'h0001}};
  localparam logic [255:0] W_NEG   = {16{16'hFFFF}};
  localparam logic [255:0] W_L0_3  = 256'd3;
  localparam logic [255:0] B_ALL   = {16{16'hFFFF}};
  localparam logic [255:0] B_L0    = {16{16'h0001}};
  localparam logic [255:0] B_101   = {208'd0, 16'h0001, 16'h0000, 16'h0001};

`ifdef SIP_SIGNED_NEURON_EN
  localparam logic [35:0] E_A = 36'hFFFFFFFF0;
  localparam logic [35:0] E_B = 36'hFFFFFFFF7;
  localparam logic [35:0] E_C = 36'd16;
  localparam logic [35:0] E_D = 36'hFFFFFFFFF;
`else
  localparam logic [35:0] E_A = 36'd240;
  localparam logic [35:0] E_B = 36'd15;
  localparam logic [35:0] E_C = 36'hFFFFFFFF0;
  localparam logic [35:0] E_D = 36'd65535;
`endif

  serial_ip_unit dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_prec      (i_prec),
    .i_weights   (i_weights),
    .i_bits      (i_bits),
    .i_bit_valid (i_bit_valid),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_sum       (o_sum)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [35:0] obs,
                     input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag,
                     input logic [4:0] prec,
                     input logic [255:0] w,
                     input logic [255:0] bseq,
                     input int n,
                     input int stall,
                     input logic [35:0] exp);
    i_start     = 1'b1;
    i_prec      = prec;
    i_weights   = w;
    i_bits      = '1;
    i_bit_valid = 1'b1;
    step();
    i_start = 1'b0;
    chk({tag, "_busy"}, 36'(o_busy), 36'd1);
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < stall; s++) begin
        i_bit_valid = 1'b0;
        i_start     = 1'b1;
        i_bits      = '1;
        step();
        chk({tag, "_stall_busy"}, 36'(o_busy), 36'd1);
        chk({tag, "_stall_valid"}, 36'(o_valid), 36'd0);
      end
      i_start     = 1'b0;
      i_bits      = bseq[i*16 +: 16];
      i_bit_valid = 1'b1;
      step();
      if (i < n - 1)
        chk({tag, "_early_valid"}, 36'(o_valid), 36'd0);
    end
    i_bit_valid = 1'b0;
    i_bits      = '0;
    chk({tag, "_valid"}, 36'(o_valid), 36'd1);
    chk({tag, "_sum"}, o_sum, exp);
    chk({tag, "_done_busy"}, 36'(o_busy), 36'd0);
    step();
    chk({tag, "_valid_off"}, 36'(o_valid), 36'd0);
    chk({tag, "_hold"}, o_sum, exp);
  endtask

  initial begin
    rst         = 1'b1;
    i_start     = 1'b0;
    i_prec      = '0;
    i_weights   = '0;
    i_bits      = '0;
    i_bit_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 36'(o_busy), 36'd0);
    chk("rst_valid", 36'(o_valid), 36'd0);
    chk("rst_sum", o_sum, 36'd0);

    i_bits      = '1;
    i_bit_valid = 1'b1;
    step();
    chk("idle_ignore", 36'(o_busy), 36'd0);
    i_bit_valid = 1'b0;

    run("ones_p4", 5'd4, W_ONE, B_ALL, 4, 0, E_A);
    run("lane0_101", 5'd3, W_L0_3, B_101, 3, 0, E_B);
    run("neg_p1", 5'd1, W_NEG, B_ALL, 1, 0, E_C);
    run("stall", 5'd4, W_ONE, B_ALL, 4, 2, E_A);
    run("p16", 5'd0, W_ONE, B_L0, 16, 0, E_D);

    i_start     = 1'b1;
    i_prec      = 5'd8;
    i_weights   = W_ONE;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_bits      = '1;
      i_bit_valid = 1'b1;
      step();
    end
    chk("abort_busy_pre", 36'(o_busy), 36'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 36'(o_busy), 36'd0);
    chk("abort_sum", o_sum, 36'd0);
    chk("abort_valid", 36'(o_valid), 36'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_valid", 36'(o_valid), 36'd0);
    end
    i_bit_valid = 1'b0;

    run("after_abort", 5'd3, W_L0_3, B_101, 3, 0, E_B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
